// File: rtl/fft_5_pkg.sv
// Shared constants, complex sample type and bit-reversal helper for the
// 16-point FFT datapath.
package fft_5_pkg;

   localparam int unsigned N_POINTS = 16;
   localparam int unsigned LOG2N    = 4;
   localparam int unsigned DATA_W   = 12;

   typedef struct packed {
      logic [DATA_W-1:0] re;
      logic [DATA_W-1:0] im;
   } cplx_t;

   function automatic logic [LOG2N-1:0] bitrev(input logic [LOG2N-1:0] a);
      logic [LOG2N-1:0] r;
      r = '0;
      for (int unsigned i = 0; i < LOG2N; i++) begin
         r[i] = a[LOG2N-1-i];
      end
      return r;
   endfunction

endpackage

// File: rtl/fft_pingpong_ram_5.sv
// Two-bank sample store: synchronous write port, asynchronous read port.
// Bank select is the address MSB.
module fft_pingpong_ram_5
   import fft_5_pkg::*;
(
   input  logic             clk,
   input  logic             we_i,
   input  logic             wr_bank_i,
   input  logic [LOG2N-1:0] wr_addr_i,
   input  cplx_t            wr_data_i,
   input  logic             rd_bank_i,
   input  logic [LOG2N-1:0] rd_addr_i,
   output cplx_t            rd_data_o
);

   cplx_t mem_q [2*N_POINTS];

   always_ff @(posedge clk) begin
      if (we_i) begin
         mem_q[{wr_bank_i, wr_addr_i}] <= wr_data_i;
      end
   end

   assign rd_data_o = mem_q[{rd_bank_i, rd_addr_i}];

endmodule

// File: rtl/fft_bitrev_buffer_5.sv
// Ping-pong input reorder buffer: natural-order samples in, completed
// 16-sample frames out in bit-reversed order at one sample per clock.
module fft_bitrev_buffer_5
   import fft_5_pkg::*;
(
   input  logic              clk,
   input  logic              rst_n,
   input  logic              clr,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [DATA_W-1:0] in_real,
   input  logic [DATA_W-1:0] in_img,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [DATA_W-1:0] out_real,
   output logic [DATA_W-1:0] out_img,
   output logic [LOG2N-1:0]  out_index,
   output logic              out_last
);

   localparam logic [LOG2N-1:0] LAST_IDX = LOG2N'(N_POINTS - 1);

   logic [1:0]        bank_full_q, bank_full_d;
   logic              wr_bank_q, rd_bank_q;
   logic [LOG2N-1:0]  wr_cnt_q, rd_cnt_q;
   logic              out_valid_q, out_last_q;
   logic [DATA_W-1:0] out_real_q, out_img_q;
   logic [LOG2N-1:0]  out_index_q;

   logic              wr_fire, rd_load, wr_wrap, rd_wrap;
   logic [LOG2N-1:0]  rd_addr;
   cplx_t             wr_data, rd_data;

   assign in_ready = ~bank_full_q[wr_bank_q];
   assign wr_fire  = in_valid & in_ready;
   assign rd_load  = (~out_valid_q | out_ready) & bank_full_q[rd_bank_q];
   assign wr_wrap  = wr_fire & (wr_cnt_q == LAST_IDX);
   assign rd_wrap  = rd_load & (rd_cnt_q == LAST_IDX);
   assign rd_addr  = bitrev(rd_cnt_q);
   assign wr_data.re = in_real;
   assign wr_data.im = in_img;

   // Set and clear always hit different banks, so both apply unconditionally.
   always_comb begin
      bank_full_d = bank_full_q;
      if (wr_wrap) bank_full_d[wr_bank_q] = 1'b1;
      if (rd_wrap) bank_full_d[rd_bank_q] = 1'b0;
   end

   fft_pingpong_ram_5 u_ram (
      .clk       (clk),
      .we_i      (wr_fire & ~clr),
      .wr_bank_i (wr_bank_q),
      .wr_addr_i (wr_cnt_q),
      .wr_data_i (wr_data),
      .rd_bank_i (rd_bank_q),
      .rd_addr_i (rd_addr),
      .rd_data_o (rd_data)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         bank_full_q <= '0;
         wr_bank_q   <= 1'b0;
         rd_bank_q   <= 1'b0;
         wr_cnt_q    <= '0;
         rd_cnt_q    <= '0;
         out_valid_q <= 1'b0;
         out_last_q  <= 1'b0;
         out_real_q  <= '0;
         out_img_q   <= '0;
         out_index_q <= '0;
      end else if (clr) begin
         bank_full_q <= '0;
         wr_bank_q   <= 1'b0;
         rd_bank_q   <= 1'b0;
         wr_cnt_q    <= '0;
         rd_cnt_q    <= '0;
         out_valid_q <= 1'b0;
         out_last_q  <= 1'b0;
      end else begin
         bank_full_q <= bank_full_d;
         // Counters are LOG2N wide, so the frame wrap is the natural rollover.
         if (wr_fire) begin
            wr_cnt_q <= wr_cnt_q + 1'b1;
            if (wr_wrap) wr_bank_q <= ~wr_bank_q;
         end
         if (rd_load) begin
            out_real_q  <= rd_data.re;
            out_img_q   <= rd_data.im;
            out_index_q <= rd_cnt_q;
            out_last_q  <= (rd_cnt_q == LAST_IDX);
            out_valid_q <= 1'b1;
            rd_cnt_q    <= rd_cnt_q + 1'b1;
            if (rd_wrap) rd_bank_q <= ~rd_bank_q;
         end else if (out_ready) begin
            out_valid_q <= 1'b0;
         end
      end
   end

   assign out_valid = out_valid_q;
   assign out_real  = out_real_q;
   assign out_img   = out_img_q;
   assign out_index = out_index_q;
   assign out_last  = out_last_q;

endmodule

// File: tb/tb_fft_bitrev_buffer_5.sv
// Scoreboard bench for fft_bitrev_buffer_5: accepted frames are reordered by a
// bench-side bit-reversal table and compared at every output handshake.
module tb_fft_bitrev_buffer_5;

   logic        clk, rst_n, clr;
   logic        in_valid, in_ready;
   logic [11:0] in_real, in_img;
   logic        out_valid, out_ready;
   logic [11:0] out_real, out_img;
   logic [3:0]  out_index;
   logic        out_last;

   fft_bitrev_buffer_5 dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .clr       (clr),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_real   (in_real),
      .in_img    (in_img),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_real  (out_real),
      .out_img   (out_img),
      .out_index (out_index),
      .out_last  (out_last)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   localparam int BR [16] = '{0, 8, 4, 12, 2, 10, 6, 14, 1, 9, 5, 13, 3, 11, 7, 15};

   typedef struct packed {
      logic [3:0]  idx;
      logic [11:0] re;
      logic [11:0] im;
   } exp_t;

   exp_t        exp_q[$];
   logic [23:0] frame_buf [16];
   int          wcount = 0;
   int          n_acc  = 0;
   int          n_out  = 0;
   int          errors = 0;
   int          checks = 0;
   logic        acc, popped;

   // One clock of stimulus; outputs observed at the negedge are the values the
   // next rising edge will see.
   task automatic cycle(input logic iv, input logic [11:0] re, input logic [11:0] im,
                        input logic ordy, input logic c);
      exp_t e;
      @(negedge clk);
      in_valid = iv; in_real = re; in_img = im; out_ready = ordy; clr = c;
      #1;
      acc    = iv && in_ready && !c;
      popped = out_valid && ordy;
      if (popped) begin
         checks++;
         n_out++;
         if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL sb_unexpected: got idx=%0d re=%0d im=%0d, required no output",
                     out_index, out_real, out_img);
         end else begin
            e = exp_q.pop_front();
            if ({out_index, out_real, out_img, out_last} !== {e.idx, e.re, e.im, (e.idx == 4'd15)}) begin
               errors++;
               $display("FAIL sb_data: got idx=%0d re=%0d im=%0d last=%0d, required idx=%0d re=%0d im=%0d last=%0d",
                        out_index, out_real, out_img, out_last, e.idx, e.re, e.im, (e.idx == 4'd15));
            end
         end
      end
      if (c) begin
         exp_q.delete();
         wcount = 0;
      end else if (acc) begin
         n_acc++;
         frame_buf[wcount] = {re, im};
         wcount++;
         if (wcount == 16) begin
            for (int i = 0; i < 16; i++) begin
               e.idx = 4'(i);
               e.re  = frame_buf[BR[i]][23:12];
               e.im  = frame_buf[BR[i]][11:0];
               exp_q.push_back(e);
            end
            wcount = 0;
         end
      end
   endtask

   task automatic drain(input int budget, output logic ok);
      int n;
      n = 0;
      while ((exp_q.size() != 0 || out_valid) && n < budget) begin
         cycle(1'b0, 12'd0, 12'd0, 1'b1, 1'b0);
         n++;
      end
      ok = (exp_q.size() == 0);
   endtask

   task automatic test_reset();
      rst_n = 1'b0; clr = 1'b0; in_valid = 1'b1; out_ready = 1'b0;
      in_real = 12'h5A5; in_img = 12'h3C3;
      repeat (3) @(negedge clk);
      #1;
      checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %0d required 0", out_valid); end
      checks++; if (out_real !== 12'd0) begin errors++; $display("FAIL reset_out_real: got %0d required 0", out_real); end
      checks++; if (out_img !== 12'd0) begin errors++; $display("FAIL reset_out_img: got %0d required 0", out_img); end
      checks++; if (out_index !== 4'd0) begin errors++; $display("FAIL reset_out_index: got %0d required 0", out_index); end
      checks++; if (out_last !== 1'b0) begin errors++; $display("FAIL reset_out_last: got %0d required 0", out_last); end
      checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready: got %0d required 1", in_ready); end
      in_valid = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   task automatic test_single_frame();
      logic ok;
      for (int k = 0; k < 16; k++) cycle(1'b1, 12'(k), 12'(-k), 1'b1, 1'b0);
      cycle(1'b0, 12'd0, 12'd0, 1'b1, 1'b0);
      checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL latency_early: out_valid got %0d required 0", out_valid); end
      cycle(1'b0, 12'd0, 12'd0, 1'b1, 1'b0);
      checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL latency: out_valid got %0d required 1", out_valid); end
      checks++; if (out_real !== 12'd0 || out_index !== 4'd0) begin
         errors++; $display("FAIL single_first: got re=%0d idx=%0d required re=0 idx=0", out_real, out_index);
      end
      drain(40, ok);
      checks++; if (!ok) begin errors++; $display("FAIL single_drain: %0d outputs missing, required 0", exp_q.size()); end
   endtask

   task automatic test_back_to_back();
      int   start, outs, gaps;
      logic started, ok, rdy_drop;
      start = n_out; outs = 0; gaps = 0; started = 1'b0; rdy_drop = 1'b0;
      for (int i = 0; i < 48; i++) begin
         cycle(1'b1, 12'(200 + i), 12'(i), 1'b1, 1'b0);
         if (!in_ready) rdy_drop = 1'b1;
         if (out_valid) started = 1'b1;
         if (started && outs < 48 && !out_valid) gaps++;
         if (out_valid) outs++;
      end
      for (int i = 0; i < 60 && outs < 48; i++) begin
         cycle(1'b0, 12'd0, 12'd0, 1'b1, 1'b0);
         if (out_valid) started = 1'b1;
         if (started && !out_valid) gaps++;
         if (out_valid) outs++;
      end
      drain(10, ok);
      checks++; if (rdy_drop) begin errors++; $display("FAIL b2b_in_ready: got a low in_ready, required always 1"); end
      checks++; if (gaps != 0) begin errors++; $display("FAIL b2b_gaps: got %0d gaps, required 0", gaps); end
      checks++; if (n_out - start != 48) begin errors++; $display("FAIL b2b_count: got %0d outputs, required 48", n_out - start); end
   endtask

   task automatic test_backpressure();
      int   acc0;
      logic ok;
      acc0 = n_acc;
      for (int i = 0; i < 33; i++) cycle(1'b1, 12'(i), 12'(-i), 1'b0, 1'b0);
      checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL bp_in_ready: got %0d required 0", in_ready); end
      checks++; if (n_acc - acc0 != 32) begin errors++; $display("FAIL bp_accepted: got %0d required 32", n_acc - acc0); end
      for (int i = 0; i < 5; i++) begin
         cycle(1'b0, 12'd0, 12'd0, 1'b0, 1'b0);
         checks++;
         if (out_valid !== 1'b1 || out_real !== 12'd0 || out_index !== 4'd0) begin
            errors++; $display("FAIL bp_hold: got v=%0d re=%0d idx=%0d required v=1 re=0 idx=0",
                               out_valid, out_real, out_index);
         end
      end
      drain(100, ok);
      checks++; if (!ok) begin errors++; $display("FAIL bp_drain: %0d outputs missing, required 0", exp_q.size()); end
      checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL bp_resume: in_ready got %0d required 1", in_ready); end
   endtask

   task automatic test_random();
      int   acc0, out0, n;
      logic ok;
      acc0 = n_acc; out0 = n_out; n = 0;
      while (n_acc - acc0 < 160 && n < 3000) begin
         cycle(1'($urandom_range(0, 1)), 12'($urandom), 12'($urandom), 1'($urandom_range(0, 1)), 1'b0);
         n++;
      end
      // The loop above stops exactly on the 160th accept; no further input is driven.
      drain(200, ok);
      checks++; if (!ok) begin errors++; $display("FAIL rand_drain: %0d outputs missing, required 0", exp_q.size()); end
      checks++; if (n_out - out0 != 160) begin errors++; $display("FAIL rand_count: got %0d outputs, required 160", n_out - out0); end
   endtask

   task automatic test_abort();
      int   out0;
      logic ok, first;
      for (int i = 0; i < 23; i++) cycle(1'b1, 12'(500 + i), 12'(i), 1'b1, 1'b0);
      cycle(1'b0, 12'd0, 12'd0, 1'b0, 1'b1);
      cycle(1'b0, 12'd0, 12'd0, 1'b1, 1'b0);
      checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL clr_out_valid: got %0d required 0", out_valid); end
      checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL clr_in_ready: got %0d required 1", in_ready); end
      for (int i = 0; i < 16; i++) cycle(1'b1, 12'(100 + i), 12'(-(100 + i)), 1'b1, 1'b0);
      first = 1'b1;
      for (int n = 0; n < 40 && exp_q.size() != 0; n++) begin
         cycle(1'b0, 12'd0, 12'd0, 1'b1, 1'b0);
         if (popped && first) begin
            first = 1'b0;
            checks++;
            if (out_index !== 4'd0 || out_real !== 12'd100) begin
               errors++; $display("FAIL clr_fresh_first: got idx=%0d re=%0d required idx=0 re=100", out_index, out_real);
            end
         end
      end
      checks++; if (exp_q.size() != 0) begin errors++; $display("FAIL clr_fresh_drain: %0d missing, required 0", exp_q.size()); end
      // A partial frame must never be emitted.
      out0 = n_out;
      for (int i = 0; i < 5; i++) cycle(1'b1, 12'(700 + i), 12'd0, 1'b1, 1'b0);
      repeat (25) cycle(1'b0, 12'd0, 12'd0, 1'b1, 1'b0);
      checks++; if (n_out != out0) begin errors++; $display("FAIL partial_frame: got %0d outputs, required 0", n_out - out0); end
      cycle(1'b0, 12'd0, 12'd0, 1'b1, 1'b1);
      drain(5, ok);
   endtask

   task automatic test_async_reset();
      int   out0;
      logic hit, ok;
      for (int i = 0; i < 16; i++) cycle(1'b1, 12'(600 + i), 12'(i), 1'b1, 1'b0);
      hit = 1'b0;
      for (int n = 0; n < 40 && !hit; n++) begin
         cycle(1'b0, 12'd0, 12'd0, 1'b1, 1'b0);
         if (out_valid && out_index == 4'd5) hit = 1'b1;
      end
      checks++; if (!hit) begin errors++; $display("FAIL arst_reach_idx5: never saw out_index=5, required yes"); end
      #2 rst_n = 1'b0;
      #1;
      checks++;
      if (out_valid !== 1'b0 || out_real !== 12'd0 || out_img !== 12'd0 || out_index !== 4'd0 || out_last !== 1'b0) begin
         errors++; $display("FAIL arst_immediate: got v=%0d re=%0d im=%0d idx=%0d last=%0d required all 0",
                            out_valid, out_real, out_img, out_index, out_last);
      end
      checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL arst_in_ready: got %0d required 1", in_ready); end
      exp_q.delete(); wcount = 0;
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      out0 = n_out;
      repeat (30) cycle(1'b0, 12'd0, 12'd0, 1'b1, 1'b0);
      checks++; if (n_out != out0) begin errors++; $display("FAIL arst_stale: got %0d outputs, required 0", n_out - out0); end
      for (int i = 0; i < 16; i++) cycle(1'b1, 12'(40 + i), 12'(-(40 + i)), 1'b1, 1'b0);
      drain(40, ok);
      checks++; if (!ok || n_out - out0 != 16) begin
         errors++; $display("FAIL arst_recover: got %0d outputs, required 16", n_out - out0);
      end
   endtask

   initial begin
      test_reset();
      test_single_frame();
      test_back_to_back();
      test_backpressure();
      test_random();
      test_abort();
      test_async_reset();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached, required completion");
      $fatal(1, "watchdog");
   end

endmodule

// File: doc/fft_bitrev_buffer_5.md
Name: fft_bitrev_buffer_5

Overview:
Input reorder stage that sits directly upstream of the first radix-2 butterfly stage of the 16-point FFT.
- Accepts complex 12-bit samples in natural order.
- Stores them in a two-bank ping-pong buffer.
- Streams each completed 16-sample frame out in bit-reversed order, so the butterflies can run decimation-in-time in place.
- One bank fills while the other drains, so throughput is one sample per clock.

Parameters:
N_POINTS, 16, frame length in complex samples (power of two)
LOG2N, 4, log2(N_POINTS); width of the sample counters
DATA_W, 12, width of each real/imag component (two's complement)

Ports:
clk  in  1  system clock, all logic on rising edge
rst_n  in  1  asynchronous active-low reset
clr  in  1  synchronous frame abort: empties both banks, zeroes all counters
in_valid  in  1  input sample valid
in_ready  out  1  buffer can accept a sample this cycle
in_real  in  DATA_W  input sample, real part
in_img  in  DATA_W  input sample, imaginary part
out_valid  out  1  output sample valid
out_ready  in  1  downstream accepts output this cycle
out_real  out  DATA_W  reordered sample, real part
out_img  out  DATA_W  reordered sample, imaginary part
out_index  out  LOG2N  output position within frame (0..N_POINTS-1), natural count
out_last  out  1  high with the final sample of a frame (out_index == N_POINTS-1)

Behaviour:
- Reset (rst_n low, async):
  - out_valid=0, out_real=0, out_img=0, out_index=0, out_last=0.
  - bank_full[1:0]=0, wr_bank=0, rd_bank=0, wr_cnt=0, rd_cnt=0.
  - Memory contents are don't-care.
- in_ready = !bank_full[wr_bank]. This is combinational from registers only, never from in_valid.
- Write (in_valid && in_ready):
  - mem[wr_bank][wr_cnt] <= {in_real, in_img}; wr_cnt++.
  - If wr_cnt == N_POINTS-1: set bank_full[wr_bank], toggle wr_bank, wr_cnt wraps to 0.
- Output register load condition: (!out_valid || out_ready) && bank_full[rd_bank].
  - out_real/out_img <= mem[rd_bank][bitrev(rd_cnt)]; out_index <= rd_cnt; out_last <= (rd_cnt == N_POINTS-1); out_valid <= 1; rd_cnt++.
  - On the last read: clear bank_full[rd_bank], toggle rd_bank, rd_cnt wraps to 0.
- If out_ready && out_valid and the load condition is false: out_valid <= 0.
- Output hold: while out_valid && !out_ready, out_* are held stable.
- Latency: the 16th input is accepted at edge E; out_valid is high after edge E+1 (one clock) if the downstream is idle.
- Sustained rate: 1 sample/clock in and out once both banks are cycling.
- Simultaneous set and clear of bank_full in the same cycle always target different banks (set needs !full, clear needs full). Both take effect.
- Both banks full: in_ready=0 and input stalls. It resumes the cycle after the draining bank's last read.
- Partial frame (wr_cnt != 0): never emitted; waits until the frame completes.
- clr has priority over writes and reads in the same cycle. Same effect as reset except out_* data is not zeroed; out_valid=0, out_last=0.
- Reset or clr mid-frame discards both banks. There is no partial output.
- Bit reversal for N=16: 0,8,4,12,2,10,6,14,1,9,5,13,3,11,7,15.

Decomposition:
- Shared package fft_5_pkg:
  - N_POINTS, LOG2N, DATA_W constants.
  - Complex sample typedef {real, img} of 2*DATA_W bits.
  - bitrev function over LOG2N bits.
  - Reused by the butterfly and twiddle stages.
- One sub-module, fft_pingpong_ram_5:
  - 2*N_POINTS x 2*DATA_W storage.
  - Write port (bank, addr, data, we) and asynchronous read port (bank, addr).
- Control (bank flags, counters, output register) stays in fft_bitrev_buffer_5.

Test Plan:
- Single frame: in_real=k, in_img=-k for k=0..15, out_ready=1. Required response:
  - Outputs in order in_real = 0,8,4,12,2,10,6,14,1,9,5,13,3,11,7,15, with in_img the matching negatives (12-bit two's complement).
  - out_index 0..15; out_last only at index 15.
  - First out_valid one clock after the 16th accept.
- Back-to-back frames: 3 frames continuous, in_valid=1 always, out_ready=1. Required response: in_ready never drops after the first frame; 48 outputs with no gaps after the first output.
- Backpressure: out_ready=0 throughout while 32 samples are sent.
  - in_ready falls after sample 32 (both banks full) and sample 33 is not accepted.
  - out_real holds 0 (stable) until out_ready=1.
  - Each subsequent frame drains correctly.
- Random out_ready (50%) and random in_valid over 10 frames. Required response: the scoreboard matches bit-reversed order with no loss or duplication.
- Abort cases:
  - Assert clr after 7 samples of frame 2: out_valid=0 next cycle and in_ready=1.
  - Then a fresh frame 100..115 emits 100,108,104,... with out_index starting at 0.
- Async reset mid-drain: drop rst_n between edges while out_index=5. Required response: all outputs zero immediately and no stale data appears after release.
